// File: rtl/sa_pkg.sv
// Shared definitions for the SA bitstream generator/decoder pair.
//   SA_N       : default value width
//   SA_L       : window length in bits (1 << SA_N)
//   sa_state_e : window FSM states (IDLE -> COUNT -> DONE)
package sa_pkg;

  localparam int unsigned SA_N = 7;
  localparam int unsigned SA_L = 1 << SA_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_e;

endpackage

// File: rtl/sa_bitstream_dec_if.sv
// Handshake and result bundle of the SA bitstream decoder.
//   start            : begin a new window (clears counters)
//   in_valid / x_in  : bitstream beat; accepted when in_ready is high
//   in_ready         : decoder is counting
//   ones_cnt/bit_cnt : live counters of the current window
//   out_valid/out_ready : result handshake carrying k_out and ovf
// slave modport is the decoder side; master modport is the producer/consumer side.
interface sa_bitstream_dec_if
  import sa_pkg::*;
#(
  parameter int unsigned N = SA_N
);

  logic         start;
  logic         in_valid;
  logic         x_in;
  logic         in_ready;
  logic [N:0]   ones_cnt;
  logic [N-1:0] bit_cnt;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] k_out;
  logic         ovf;

  modport slave (
    input  start, in_valid, x_in, out_ready,
    output in_ready, ones_cnt, bit_cnt, out_valid, k_out, ovf
  );

  modport master (
    output start, in_valid, x_in, out_ready,
    input  in_ready, ones_cnt, bit_cnt, out_valid, k_out, ovf
  );

endinterface

// File: rtl/sa_bitstream_dec.sv
// Streaming decoder for unary SA bitstreams: counts ones over a window of
// L = 2^N accepted beats and returns k (or ovf when all L bits were ones).
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sa_bitstream_dec_if.slave (start, beat input, live counters,
//           result handshake)
module sa_bitstream_dec
  import sa_pkg::*;
#(
  parameter int unsigned N = SA_N
) (
  input  logic               clk,
  input  logic               rst_n,
  sa_bitstream_dec_if.slave  bus
);

  localparam int unsigned L  = 1 << N;
  localparam int unsigned CW = N + 1;

  sa_state_e       state_q, state_d;
  logic [CW-1:0]   ones_q, ones_d;
  logic [N-1:0]    bits_q, bits_d;
  logic [N-1:0]    k_q, k_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            last_beat;
  logic [CW-1:0]   ones_inc;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ones_q      <= '0;
      bits_q      <= '0;
      k_q         <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      bits_q      <= bits_d;
      k_q         <= k_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, counters and result capture
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    bits_d    = bits_q;
    k_d       = k_q;
    ovf_d     = ovf_q;

    // in_ready_q mirrors state_q == ST_COUNT, so accept needs no state decode
    accept    = bus.in_valid && in_ready_q;
    last_beat = (bits_q == N'(L - 1));
    ones_inc  = ones_q + CW'(bus.x_in);

    if (bus.start) begin
      // start beats any in-flight beat or pending result
      state_d = ST_COUNT;
      ones_d  = '0;
      bits_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_COUNT: begin
          if (accept) begin
            ones_d = ones_inc;
            bits_d = bits_q + N'(1);
            if (last_beat) begin
              // L ones do not fit in N bits: flag and report zero
              ovf_d   = (ones_inc == CW'(L));
              k_d     = (ones_inc == CW'(L)) ? '0 : ones_inc[N-1:0];
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Handshake flags are registered decodes of the next state
    in_ready_d  = (state_d == ST_COUNT);
    out_valid_d = (state_d == ST_DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ones_cnt  = ones_q;
  assign bus.bit_cnt   = bits_q;
  assign bus.k_out     = k_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sa_bitstream_dec.sv
// Self-checking bench for sa_bitstream_dec: directed windows push expected
// results into a scoreboard queue; a monitor pops and compares on each
// result handshake. Inline checks cover latency, counters and reset.
module tb_sa_bitstream_dec;
  import sa_pkg::*;

  localparam int unsigned N = SA_N;
  localparam int unsigned L = SA_L;

  typedef struct packed {
    logic [N-1:0] k;
    logic         ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sa_bitstream_dec_if #(.N(N)) bus ();

  sa_bitstream_dec #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ones = 0;
  int   m_bits = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L-1:0] mk_stride(input int count, input int stride);
    logic [L-1:0] p;
    p = '0;
    for (int i = 0; i < count; i++) p[i*stride] = 1'b1;
    return p;
  endfunction

  // Result monitor: pops one expectation per completed handshake
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got k=%0d ovf=%0d expected none",
                   bus.k_out, bus.ovf);
        end else begin
          e = exp_q.pop_front();
          check("k_out", int'(bus.k_out), int'(e.k));
          check("ovf", int'(bus.ovf), int'(e.ovf));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    m_ones    = 0;
    m_bits    = 0;
  endtask

  task automatic send(input logic [L-1:0] pat, input int nbits, input bit throttle);
    for (int i = 0; i < nbits; i++) begin
      if (throttle) begin
        while ($urandom_range(0, 1) == 1) begin
          bus.in_valid = 1'b0;
          bus.x_in     = 1'($urandom_range(0, 1));
          tick();
          check("ones_hold", int'(bus.ones_cnt), m_ones);
          check("bits_hold", int'(bus.bit_cnt), m_bits % L);
        end
      end
      bus.in_valid = 1'b1;
      bus.x_in     = pat[i];
      tick();
      m_ones += int'(pat[i]);
      m_bits++;
      if (throttle) begin
        check("ones_live", int'(bus.ones_cnt), m_ones);
        check("bits_live", int'(bus.bit_cnt), m_bits % L);
      end
    end
    bus.in_valid = 1'b0;
    bus.x_in     = 1'b0;
  endtask

  task automatic push_exp(input int k, input bit o);
    exp_t e;
    e.k   = N'(k);
    e.ovf = o;
    exp_q.push_back(e);
  endtask

  task automatic run_window(input string tag, input logic [L-1:0] pat, input int exp_k,
                            input bit exp_ovf, input int exp_ones, input bit throttle);
    do_start();
    check({tag, "_in_ready_after_start"}, int'(bus.in_ready), 1);
    check({tag, "_ones_cleared"}, int'(bus.ones_cnt), 0);
    check({tag, "_bits_cleared"}, int'(bus.bit_cnt), 0);
    push_exp(exp_k, exp_ovf);
    send(pat, L, throttle);
    check({tag, "_out_valid_latency"}, int'(bus.out_valid), 1);
    check({tag, "_in_ready_done"}, int'(bus.in_ready), 0);
    tick();
    check({tag, "_out_valid_drop"}, int'(bus.out_valid), 0);
    check({tag, "_final_ones"}, int'(bus.ones_cnt), exp_ones);
    check({tag, "_final_bits"}, int'(bus.bit_cnt), 0);
  endtask

  initial begin : stim
    logic [L-1:0] p;
    int           loop_k[5];

    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x_in      = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    tick();
    tick();
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_k_out", int'(bus.k_out), 0);
    check("rst_ones", int'(bus.ones_cnt), 0);
    check("rst_bits", int'(bus.bit_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", int'(bus.in_ready), 0);

    // Alternating 1/0, all ones, all zeros
    run_window("alt", mk_stride(64, 2), 64, 1'b0, 64, 1'b0);
    run_window("ones", mk_stride(128, 1), 0, 1'b1, 128, 1'b0);
    run_window("zeros", mk_stride(0, 1), 0, 1'b0, 0, 1'b0);

    // k = 20 with throttled in_valid
    run_window("k20", mk_stride(20, 6), 20, 1'b0, 20, 1'b1);

    // Back-pressure: single one on the last beat, out_ready low for 10 cycles
    p        = '0;
    p[L-1]   = 1'b1;
    do_start();
    push_exp(1, 1'b0);
    bus.out_ready = 1'b0;
    send(p, L, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_k_out", int'(bus.k_out), 1);
      check("hold_in_ready", int'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("hold_release_out_valid", int'(bus.out_valid), 0);
    check("hold_release_in_ready", int'(bus.in_ready), 0);

    // Restart after 50 beats, then a full k = 32 window
    do_start();
    send(mk_stride(64, 2), 50, 1'b0);
    check("partial_ones_50", int'(bus.ones_cnt), 25);
    check("partial_bits_50", int'(bus.bit_cnt), 50);
    run_window("k32", mk_stride(32, 4), 32, 1'b0, 32, 1'b0);

    // start together with the last beat: beat discarded, no result
    do_start();
    send(mk_stride(128, 1), L - 1, 1'b0);
    check("pre_last_bits", int'(bus.bit_cnt), L - 1);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in     = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("collide_ones", int'(bus.ones_cnt), 0);
    check("collide_bits", int'(bus.bit_cnt), 0);
    check("collide_in_ready", int'(bus.in_ready), 1);
    check("collide_out_valid", int'(bus.out_valid), 0);
    tick();
    check("collide_no_result", int'(bus.out_valid), 0);

    // Reset mid-window
    do_start();
    send(mk_stride(128, 1), 30, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_ovf", int'(bus.ovf), 0);
    check("midrst_k_out", int'(bus.k_out), 0);
    check("midrst_ones", int'(bus.ones_cnt), 0);
    check("midrst_bits", int'(bus.bit_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("midrst_no_result", int'(bus.out_valid), 0);

    // Unary loopback streams (k ones first, as the generator emits)
    loop_k = '{2, 16, 64, 96, 127};
    foreach (loop_k[j]) begin
      run_window("loop", mk_stride(loop_k[j], 1), loop_k[j], 1'b0, loop_k[j], 1'b0);
    end

    tick();
    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
